sparc_window_regfile: RTL and testbench
=======================================

# sparc_window_regfile

Windowed SPARC V8 integer register file: 8 globals plus NWINDOWS overlapping 16-register windows, with CWP and WIM state and SAVE/RESTORE window-trap detection. Sits directly upstream of the operand-select multiplexers: its two read ports drive the 32-bit operand muxes feeding the ALU. Its write port is driven by the write-back stage.

## Interface
- NWINDOWS, 4, number of register windows; power of two, 2..32
- CWPW, $clog2(NWINDOWS), width of CWP
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rs1_addr  in  5  logical source register 1
- rs2_addr  in  5  logical source register 2
- rs1_data  out  32  contents of rs1 in current window
- rs2_data  out  32  contents of rs2 in current window
- we  in  1  register write enable
- rd_addr  in  5  logical destination register
- rd_data  in  32  write data
- save  in  1  request CWP decrement
- restore  in  1  request CWP increment
- cwp_load  in  1  load CWP from cwp_in (WRPSR)
- cwp_in  in  CWPW  new CWP value
- wim_we  in  1  load WIM from wim_in
- wim_in  in  NWINDOWS  new window invalid mask
- cwp  out  CWPW  current window pointer
- wim  out  NWINDOWS  current window invalid mask
- trap_overflow  out  1  one-cycle pulse: SAVE rejected
- trap_underflow  out  1  one-cycle pulse: RESTORE rejected

## Operation
- Physical storage: 8 + 16*NWINDOWS registers of 32 bits.
- Logical-to-physical map with window w = cwp:
  - r0..r7 → phys 0..7 (globals)
  - r8..r31 → phys 8 + ((16*w + r − 8) mod 16*NWINDOWS)
  - Consequence: ins (r24..r31) of window w are the outs (r8..r15) of window w+1 (mod NWINDOWS).
- r0 reads 0 always; writes to r0 are discarded.
- Reads are combinational from current cwp and storage; no write bypass (read during write returns the old value).
- Write: on clock edge with we=1, rd_data stored at the physical register mapped using the pre-edge cwp.
- CWP update at each edge, priority order:
  - cwp_load=1: cwp ← cwp_in; save/restore ignored; no trap.
  - save=1 and restore=1: illegal; cwp unchanged; no trap.
  - save=1: n = (cwp − 1) mod NWINDOWS. If wim[n]=1: cwp unchanged, trap_overflow=1 next cycle. Else cwp ← n.
  - restore=1: n = (cwp + 1) mod NWINDOWS. If wim[n]=1: cwp unchanged, trap_underflow=1 next cycle. Else cwp ← n.
- WIM: wim_we=1 loads wim_in at the edge. Save/restore checks in the same cycle use the pre-edge wim.
- Traps are registered; each is high for exactly one cycle per rejected request. Back-to-back rejected requests give a continuously high trap.

## Timing
- Reset (synchronous, reset=1 at an edge):
  - all physical registers ← 0; cwp ← 0; wim ← 0
  - trap_overflow ← 0; trap_underflow ← 0
  - reset overrides every other input in that cycle, including a write or save in progress.
- Read latency 0 cycles. Reads follow the new cwp immediately after the updating edge.
- Write latency 1 edge. A write issued in the same cycle as save lands in the old window. The control unit issues the SAVE/RESTORE destination write in the following cycle.
- Trap latency: asserted in the cycle following the request edge; cleared after one cycle unless re-triggered.
- No internal stall; every input is sampled every cycle.

## Test plan
- Reset, then read r0..r31 → all 0. cwp=0, wim=0, traps=0. Write r0=0xFFFFFFFF → r0 still reads 0.
- cwp=0: write r8=0x11111111. Then save → cwp=3 (NWINDOWS=4) and r24 reads 0x11111111. Then restore → cwp=0 and r8 reads 0x11111111.
- Write r16=0xA5A5A5A5 in window 0, save, read r16 → 0. Write r3=0x3 in window 0, save, read r3 → 0x3 (globals shared).
- wim=4'b1000, cwp=0, save → cwp stays 0 and trap_overflow high for exactly one cycle. wim=4'b0010, cwp=0, restore → cwp stays 0 and trap_underflow pulses once.
- Same-cycle cases: save+restore → cwp unchanged, no trap. cwp_load with cwp_in=2 plus save → cwp=2. wim_we with wim_in=4'b1000 plus save from cwp=0 → cwp=3, no trap (old wim used).
- Mid-operation reset: cwp=2, wim=4'b0001, registers written; assert reset for one edge together with we and save → all registers 0, cwp=0, wim=0, no trap next cycle.

Source files
------------

// File: rtl/sparc_window_regfile.sv
// Windowed SPARC V8 integer register file: 8 globals plus NWINDOWS overlapping
// 16-register windows, with CWP/WIM state and SAVE/RESTORE trap detection.
module sparc_window_regfile #(
  parameter int NWINDOWS = 4,
  parameter int CWPW     = $clog2(NWINDOWS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          rs1_addr,
  input  logic [4:0]          rs2_addr,
  output logic [31:0]         rs1_data,
  output logic [31:0]         rs2_data,
  input  logic                we,
  input  logic [4:0]          rd_addr,
  input  logic [31:0]         rd_data,
  input  logic                save,
  input  logic                restore,
  input  logic                cwp_load,
  input  logic [CWPW-1:0]     cwp_in,
  input  logic                wim_we,
  input  logic [NWINDOWS-1:0] wim_in,
  output logic [CWPW-1:0]     cwp,
  output logic [NWINDOWS-1:0] wim,
  output logic                trap_overflow,
  output logic                trap_underflow
);

  localparam int NPHYS = 8 + 16 * NWINDOWS;
  localparam int OW    = CWPW + 4;  // offset within the windowed region
  localparam int PW    = CWPW + 5;  // physical index width

  logic [31:0]         regs_reg [NPHYS];
  logic [CWPW-1:0]     cwp_reg;
  logic [NWINDOWS-1:0] wim_reg;
  logic                ovf_reg;
  logic                unf_reg;

  logic [PW-1:0]       rs1_phys;
  logic [PW-1:0]       rs2_phys;
  logic [PW-1:0]       wr_phys;
  logic                wr_en;
  logic [CWPW-1:0]     cwp_dec;
  logic [CWPW-1:0]     cwp_inc;

  // Windowed registers wrap modulo 16*NWINDOWS, which is a power of two, so
  // truncation of the offset to OW bits performs the modulo.
  function automatic logic [PW-1:0] map_phys(input logic [4:0] r, input logic [CWPW-1:0] w);
    logic [OW-1:0] off;
    off = {w, 4'b0000} + OW'(r - 5'd8);
    if (r[4:3] == 2'b00)
      map_phys = PW'(r);
    else
      map_phys = PW'(8) + PW'(off);
  endfunction

  assign rs1_phys = map_phys(rs1_addr, cwp_reg);
  assign rs2_phys = map_phys(rs2_addr, cwp_reg);
  assign wr_phys  = map_phys(rd_addr, cwp_reg);
  assign wr_en    = we && (rd_addr != 5'd0);

  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs_reg[rs1_phys];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs_reg[rs2_phys];

  assign cwp_dec = cwp_reg - CWPW'(1);
  assign cwp_inc = cwp_reg + CWPW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NPHYS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset)
          regs_reg[gi] <= 32'd0;
        else if (wr_en && (wr_phys == PW'(gi)))
          regs_reg[gi] <= rd_data;
      end
    end
  endgenerate

  // Save/restore validity is judged against the pre-edge WIM.
  always_ff @(posedge clk) begin
    if (reset) begin
      cwp_reg <= '0;
      wim_reg <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
      if (wim_we)
        wim_reg <= wim_in;
      if (cwp_load) begin
        cwp_reg <= cwp_in;
      end else if (save && restore) begin
        cwp_reg <= cwp_reg;
      end else if (save) begin
        if (wim_reg[cwp_dec])
          ovf_reg <= 1'b1;
        else
          cwp_reg <= cwp_dec;
      end else if (restore) begin
        if (wim_reg[cwp_inc])
          unf_reg <= 1'b1;
        else
          cwp_reg <= cwp_inc;
      end
    end
  end

  assign cwp            = cwp_reg;
  assign wim            = wim_reg;
  assign trap_overflow  = ovf_reg;
  assign trap_underflow = unf_reg;

endmodule

// File: tb/tb_sparc_window_regfile.sv
// Testbench for sparc_window_regfile: directed scenarios plus randomized
// traffic checked against a flat-array architectural model.
module tb_sparc_window_regfile;

  localparam int N     = 4;
  localparam int CW    = $clog2(N);
  localparam int NPHYS = 8 + 16 * N;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
  logic [31:0]   rs1_data, rs2_data, rd_data = '0;
  logic          we = 1'b0, save = 1'b0, restore = 1'b0, cwp_load = 1'b0, wim_we = 1'b0;
  logic [CW-1:0] cwp_in = '0, cwp;
  logic [N-1:0]  wim_in = '0, wim;
  logic          trap_overflow, trap_underflow;

  int total = 0;
  int bad = 0;

  logic [31:0] m_regs [NPHYS];
  int          m_cwp;
  logic [N-1:0] m_wim;
  bit          m_tov, m_tun;

  always #5 clk = ~clk;

  sparc_window_regfile #(.NWINDOWS(N)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
    .save(save), .restore(restore),
    .cwp_load(cwp_load), .cwp_in(cwp_in),
    .wim_we(wim_we), .wim_in(wim_in),
    .cwp(cwp), .wim(wim),
    .trap_overflow(trap_overflow), .trap_underflow(trap_underflow)
  );

  function automatic int phys_of(int r, int w);
    if (r < 8) return r;
    return 8 + ((16 * w + r - 8) % (16 * N));
  endfunction

  function automatic logic [31:0] mread(int r);
    if (r == 0) return 32'd0;
    return m_regs[phys_of(r, m_cwp)];
  endfunction

  // Drive one cycle of inputs, advance the model, and return 1ns after the edge.
  task automatic step(input bit rst, input bit w_en, input int rd, input logic [31:0] d,
                      input bit sv, input bit rs, input bit ld, input int cin,
                      input bit wwe, input logic [N-1:0] win);
    int n;
    reset = rst; we = w_en; rd_addr = 5'(rd); rd_data = d;
    save = sv; restore = rs; cwp_load = ld; cwp_in = CW'(cin);
    wim_we = wwe; wim_in = win;
    if (rst) begin
      for (int i = 0; i < NPHYS; i++) m_regs[i] = 32'd0;
      m_cwp = 0; m_wim = '0; m_tov = 0; m_tun = 0;
    end else begin
      if (w_en && rd != 0) m_regs[phys_of(rd, m_cwp)] = d;
      m_tov = 0; m_tun = 0;
      if (ld) m_cwp = cin;
      else if (sv && rs) ;
      else if (sv) begin
        n = (m_cwp + N - 1) % N;
        if (m_wim[n]) m_tov = 1; else m_cwp = n;
      end else if (rs) begin
        n = (m_cwp + 1) % N;
        if (m_wim[n]) m_tun = 1; else m_cwp = n;
      end
      if (wwe) m_wim = win;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 32'd0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 32'd0, 0, 0, 0, 0, 0, '0);
    idle();
    total++; if (cwp !== '0) begin bad++; $display("FAIL reset_cwp got=%0d want=0", cwp); end
    total++; if (wim !== '0) begin bad++; $display("FAIL reset_wim got=%b want=0", wim); end
    total++;
    if (trap_overflow !== 1'b0 || trap_underflow !== 1'b0) begin
      bad++; $display("FAIL reset_traps got=%b%b want=00", trap_overflow, trap_underflow);
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); #1;
      total++;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
        bad++; $display("FAIL reset_read r%0d got=%h/%h want=0", i, rs1_data, rs2_data);
      end
    end
    step(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, '0);
    idle();
    rs1_addr = 5'd0; #1;
    total++; if (rs1_data !== 32'd0) begin bad++; $display("FAIL r0_write got=%h want=0", rs1_data); end
  endtask

  task automatic test_overlap();
    step(1, 0, 0, 32'd0, 0, 0, 0, 0, 0, '0);
    step(0, 1, 8, 32'h1111_1111, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 32'd0, 1, 0, 0, 0, 0, '0);
    idle();
    total++; if (cwp !== CW'(3)) begin bad++; $display("FAIL save_cwp got=%0d want=3", cwp); end
    rs1_addr = 5'd24; #1;
    total++; if (rs1_data !== 32'h1111_1111) begin bad++; $display("FAIL ins_outs got=%h want=11111111", rs1_data); end
    step(0, 0, 0, 32'd0, 0, 1, 0, 0, 0, '0);
    idle();
    total++; if (cwp !== CW'(0)) begin bad++; $display("FAIL restore_cwp got=%0d want=0", cwp); end
    rs2_addr = 5'd8; #1;
    total++; if (rs2_data !== 32'h1111_1111) begin bad++; $display("FAIL restore_r8 got=%h want=11111111", rs2_data); end
  endtask

  task automatic test_locals_globals();
    step(1, 0, 0, 32'd0, 0, 0, 0, 0, 0, '0);
    step(0, 1, 16, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 32'd0, 1, 0, 0, 0, 0, '0);
    rs1_addr = 5'd16; #1;
    total++; if (rs1_data !== 32'd0) begin bad++; $display("FAIL local_private got=%h want=0", rs1_data); end
    step(0, 1, 3, 32'h3, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 32'd0, 1, 0, 0, 0, 0, '0);
    rs1_addr = 5'd3; #1;
    total++; if (rs1_data !== 32'h3) begin bad++; $display("FAIL global_shared got=%h want=3", rs1_data); end
  endtask

  task automatic test_traps();
    step(1, 0, 0, 32'd0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 32'd0, 0, 0, 0, 0, 1, 4'b1000);
    step(0, 0, 0, 32'd0, 1, 0, 0, 0, 0, '0);
    total++;
    if (trap_overflow !== 1'b1 || cwp !== CW'(0)) begin
      bad++; $display("FAIL ovf_pulse got=%b cwp=%0d want=1 cwp=0", trap_overflow, cwp);
    end
    idle();
    total++; if (trap_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", trap_overflow); end
    step(0, 0, 0, 32'd0, 0, 0, 0, 0, 1, 4'b0010);
    step(0, 0, 0, 32'd0, 0, 1, 0, 0, 0, '0);
    total++;
    if (trap_underflow !== 1'b1 || cwp !== CW'(0)) begin
      bad++; $display("FAIL unf_pulse got=%b cwp=%0d want=1 cwp=0", trap_underflow, cwp);
    end
    idle();
    total++; if (trap_underflow !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b want=0", trap_underflow); end
  endtask

  task automatic test_same_cycle();
    step(1, 0, 0, 32'd0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 32'd0, 1, 1, 0, 0, 0, '0);
    total++;
    if (cwp !== CW'(0) || trap_overflow !== 1'b0 || trap_underflow !== 1'b0) begin
      bad++; $display("FAIL save_restore got=cwp%0d traps%b%b want=cwp0 traps00", cwp, trap_overflow, trap_underflow);
    end
    step(0, 0, 0, 32'd0, 1, 0, 1, 2, 0, '0);
    total++; if (cwp !== CW'(2)) begin bad++; $display("FAIL load_wins got=%0d want=2", cwp); end
    step(1, 0, 0, 32'd0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 32'd0, 1, 0, 0, 0, 1, 4'b1000);
    total++;
    if (cwp !== CW'(3) || trap_overflow !== 1'b0 || wim !== 4'b1000) begin
      bad++; $display("FAIL old_wim got=cwp%0d ovf%b wim%b want=cwp3 ovf0 wim1000", cwp, trap_overflow, wim);
    end
  endtask

  task automatic test_mid_reset();
    step(1, 0, 0, 32'd0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 32'd0, 0, 0, 1, 2, 1, 4'b0001);
    for (int r = 1; r < 32; r++) step(0, 1, r, 32'hC0DE_0000 + 32'(r), 0, 0, 0, 0, 0, '0);
    step(1, 1, 9, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, '0);
    total++;
    if (cwp !== CW'(0) || wim !== '0 || trap_overflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset_state got=cwp%0d wim%b ovf%b want=0 0 0", cwp, wim, trap_overflow);
    end
    step(0, 0, 0, 32'd0, 0, 0, 1, 2, 0, '0);
    total++;
    if (trap_overflow !== 1'b0 || trap_underflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset_trap got=%b%b want=00", trap_overflow, trap_underflow);
    end
    for (int r = 0; r < 32; r++) begin
      rs1_addr = 5'(r); #1;
      total++; if (rs1_data !== 32'd0) begin bad++; $display("FAIL mid_reset_r%0d got=%h want=0", r, rs1_data); end
    end
  endtask

  task automatic test_random();
    bit rst, w_en, sv, rs, ld, wwe;
    int rd, cin;
    logic [31:0] d;
    logic [N-1:0] win;
    step(1, 0, 0, 32'd0, 0, 0, 0, 0, 0, '0);
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom_range(0, 63) == 0);
      w_en = $urandom_range(0, 1) == 1;
      rd   = $urandom_range(0, 31);
      d    = $urandom;
      sv   = ($urandom_range(0, 2) == 0);
      rs   = ($urandom_range(0, 2) == 0);
      ld   = ($urandom_range(0, 15) == 0);
      cin  = $urandom_range(0, N - 1);
      wwe  = ($urandom_range(0, 7) == 0);
      win  = N'($urandom);
      we = w_en; rd_addr = 5'(rd); rd_data = d;
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = (k % 4 == 0) ? 5'(rd) : 5'($urandom_range(0, 31));
      #1;
      total++;
      if (rs1_data !== mread(int'(rs1_addr)) || rs2_data !== mread(int'(rs2_addr))) begin
        bad++;
        $display("FAIL rand_read k=%0d r%0d=%h r%0d=%h want %h %h", k, rs1_addr, rs1_data,
                 rs2_addr, rs2_data, mread(int'(rs1_addr)), mread(int'(rs2_addr)));
      end
      total++;
      if (cwp !== CW'(m_cwp) || wim !== m_wim || trap_overflow !== m_tov || trap_underflow !== m_tun) begin
        bad++;
        $display("FAIL rand_state k=%0d got cwp%0d wim%b t%b%b want cwp%0d wim%b t%b%b", k, cwp, wim,
                 trap_overflow, trap_underflow, m_cwp, m_wim, m_tov, m_tun);
      end
      step(rst, w_en, rd, d, sv, rs, ld, cin, wwe, win);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_locals_globals();
    test_traps();
    test_same_cycle();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
